// File: rtl/load_store_align.sv
// load_store_align: sub-word data-memory access unit.
// Stores: packs a register value into byte/halfword/word lanes with byte enables.
// Loads: extracts the addressed lane from the memory word and sign/zero-extends it.
// Talks to memory through a req/ack handshake, so multi-cycle memories are tolerated.
module load_store_align (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        start,
    input  logic        MemWrite,
    input  logic [1:0]  size,
    input  logic        ExtSel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // Access size encodings.
    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzWord = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Captured access attributes, held for the whole of REQ.
    logic        we_q;
    logic [1:0]  size_q;
    logic        ext_q;
    logic [1:0]  lane_q;
    logic        misalign_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rdata_q;

    // Decoded values for the access currently presented on the inputs.
    logic        accept;
    logic        illegal;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;

    // Load-path extraction from the returned memory word.
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;
    logic        load_complete;

    assign accept        = (state_q == StIdle) && start;
    assign load_complete = (state_q == StReq) && mem_ack && !we_q;

    // Alignment check: halfwords need addr[0] clear, words need addr[1:0] clear.
    always_comb begin
        illegal = 1'b0;
        case (size)
            SzByte:  illegal = 1'b0;
            SzHalf:  illegal = addr[0];
            SzWord:  illegal = (addr[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    // Byte enables and lane-replicated store data for the requested size.
    always_comb begin
        be_calc    = 4'b0000;
        wdata_calc = wdata;
        case (size)
            SzByte: begin
                be_calc    = 4'b0001 << addr[1:0];
                wdata_calc = {4{wdata[7:0]}};
            end
            SzHalf: begin
                be_calc    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{wdata[15:0]}};
            end
            SzWord: begin
                be_calc    = 4'b1111;
                wdata_calc = wdata;
            end
            default: begin
                be_calc    = 4'b0000;
                wdata_calc = wdata;
            end
        endcase
    end

    // State register; reset drops straight back to IDLE.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = illegal ? StDone : StReq;
                end
            end
            StReq: begin
                if (mem_ack) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            StIdle: begin
                busy = 1'b0;
            end
            StReq: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = we_q;
            end
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Capture the access when it is accepted in IDLE; starts while busy are dropped.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            we_q        <= 1'b0;
            size_q      <= SzByte;
            ext_q       <= 1'b0;
            lane_q      <= 2'b00;
            misalign_q  <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
        end else if (accept) begin
            we_q        <= MemWrite;
            size_q      <= size;
            ext_q       <= ExtSel;
            lane_q      <= addr[1:0];
            misalign_q  <= illegal;
            mem_addr_q  <= {addr[31:2], 2'b00};
            mem_be_q    <= be_calc;
            mem_wdata_q <= wdata_calc;
        end
    end

    // Select the addressed lane and extend it to 32 bits.
    always_comb begin
        byte_lane = 8'h00;
        unique case (lane_q)
            2'd0: byte_lane = mem_rdata[7:0];
            2'd1: byte_lane = mem_rdata[15:8];
            2'd2: byte_lane = mem_rdata[23:16];
            2'd3: byte_lane = mem_rdata[31:24];
        endcase
        half_lane = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_val  = mem_rdata;
        case (size_q)
            SzByte:  load_val = {{24{ext_q & byte_lane[7]}}, byte_lane};
            SzHalf:  load_val = {{16{ext_q & half_lane[15]}}, half_lane};
            default: load_val = mem_rdata;
        endcase
    end

    // Load result register: only a completed load updates it.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            rdata_q <= 32'h0;
        end else if (load_complete) begin
            rdata_q <= load_val;
        end
    end

    assign misalign  = misalign_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_align.sv
// Directed bench for load_store_align with hand-computed expectations.
module tb_load_store_align;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic        MemWrite = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        ExtSel = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy;
    logic        done;
    logic        misalign;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;

    int n_cmp = 0;
    int n_err = 0;

    load_store_align dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .start     (start),
        .MemWrite  (MemWrite),
        .size      (size),
        .ExtSel    (ExtSel),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .misalign  (misalign),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one access with start for a single edge; returns 1 time unit after that edge.
    task automatic do_start(input logic we, input logic [1:0] sz, input logic ext,
                            input logic [31:0] a, input logic [31:0] wd);
        @(negedge CLK);
        MemWrite = we;
        size     = sz;
        ExtSel   = ext;
        addr     = a;
        wdata    = wd;
        start    = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #2;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_misalign", misalign, 0);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_be", mem_be, 0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge CLK);
        Reset = 1'b0;

        // sb, zero-wait memory
        do_start(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5);
        check_eq("sb_req", mem_req, 1);
        check_eq("sb_we", mem_we, 1);
        check_eq("sb_be", mem_be, 4'b1000);
        check_eq("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        check_eq("sb_addr", mem_addr, 32'h0000_1000);
        check_eq("sb_busy", busy, 1);
        check_eq("sb_done_early", done, 0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("sb_done", done, 1);
        check_eq("sb_misalign", misalign, 0);
        check_eq("sb_req_off", mem_req, 0);
        check_eq("sb_rdata_kept", rdata, 32'h0);
        tick();
        check_eq("sb_done_one", done, 0);
        check_eq("sb_idle", busy, 0);

        // lb signed at lane 1
        mem_rdata = 32'h80FF_7F01;
        do_start(1'b0, 2'b00, 1'b1, 32'h0000_2001, 32'h0);
        check_eq("lb1_be", mem_be, 4'b0010);
        check_eq("lb1_we", mem_we, 0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("lb1_done", done, 1);
        check_eq("lb1_rdata", rdata, 32'h0000_007F);
        tick();
        // lb signed at lane 2
        do_start(1'b0, 2'b00, 1'b1, 32'h0000_2002, 32'h0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("lb2s_rdata", rdata, 32'hFFFF_FFFF);
        tick();
        // lbu at lane 2
        do_start(1'b0, 2'b00, 1'b0, 32'h0000_2002, 32'h0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("lb2u_rdata", rdata, 32'h0000_00FF);
        tick();

        // lh upper half, memory waits 3 cycles
        mem_rdata = 32'hXXXX_XXXX;
        do_start(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check_eq("lh_wait_req", mem_req, 1);
            check_eq("lh_wait_we", mem_we, 0);
            check_eq("lh_wait_be", mem_be, 4'b1100);
            check_eq("lh_wait_addr", mem_addr, 32'h0000_2000);
            check_eq("lh_wait_done", done, 0);
            check_eq("lh_wait_rdata", rdata, 32'h0000_00FF);
            tick();
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h8001_1234;
        tick();
        mem_ack = 1'b0;
        check_eq("lh_done", done, 1);
        check_eq("lh_rdata", rdata, 32'hFFFF_8001);
        tick();

        // lhu lower half
        mem_rdata = 32'h1234_F00D;
        do_start(1'b0, 2'b01, 1'b0, 32'h0000_6000, 32'h0);
        check_eq("lhu_be", mem_be, 4'b0011);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("lhu_rdata", rdata, 32'h0000_F00D);
        tick();
        mem_rdata = 32'h0;

        // Misaligned accesses: sh @3001, lw @3002, size 11
        do_start(1'b1, 2'b01, 1'b0, 32'h0000_3001, 32'h1111_2222);
        check_eq("sh_mis_done", done, 1);
        check_eq("sh_mis_flag", misalign, 1);
        check_eq("sh_mis_req", mem_req, 0);
        tick();
        check_eq("sh_mis_idle", busy, 0);
        do_start(1'b0, 2'b10, 1'b0, 32'h0000_3002, 32'h0);
        check_eq("lw_mis_done", done, 1);
        check_eq("lw_mis_flag", misalign, 1);
        check_eq("lw_mis_req", mem_req, 0);
        tick();
        check_eq("lw_mis_rdata", rdata, 32'h0000_F00D);
        do_start(1'b0, 2'b11, 1'b0, 32'h0000_3000, 32'h0);
        check_eq("sz11_done", done, 1);
        check_eq("sz11_flag", misalign, 1);
        check_eq("sz11_req", mem_req, 0);
        tick();
        check_eq("sz11_rdata", rdata, 32'h0000_F00D);

        // Reset asserted while in REQ
        do_start(1'b1, 2'b10, 1'b0, 32'h0000_4000, 32'hDEAD_BEEF);
        check_eq("rreq_req", mem_req, 1);
        #2;
        Reset = 1'b1;
        #1;
        check_eq("rreq_req_drop", mem_req, 0);
        check_eq("rreq_busy", busy, 0);
        tick();
        check_eq("rreq_no_done", done, 0);
        @(negedge CLK);
        Reset = 1'b0;
        tick();
        check_eq("rreq_after_busy", busy, 0);
        check_eq("rreq_after_done", done, 0);

        // Fresh sw after reset
        do_start(1'b1, 2'b10, 1'b0, 32'h0000_4004, 32'h1234_5678);
        check_eq("sw_be", mem_be, 4'b1111);
        check_eq("sw_wdata", mem_wdata, 32'h1234_5678);
        check_eq("sw_addr", mem_addr, 32'h0000_4004);
        check_eq("sw_we", mem_we, 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("sw_done", done, 1);
        check_eq("sw_misalign", misalign, 0);
        tick();

        // Stray ack in IDLE
        @(negedge CLK);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("stray_busy", busy, 0);
        check_eq("stray_done", done, 0);
        check_eq("stray_req", mem_req, 0);

        // sh upper half, start held through REQ and DONE with different inputs
        do_start(1'b1, 2'b01, 1'b0, 32'h0000_5002, 32'hCAFE_BABE);
        check_eq("sh_be", mem_be, 4'b1100);
        check_eq("sh_wdata", mem_wdata, 32'hBABE_BABE);
        start    = 1'b1;
        addr     = 32'h0000_7001;
        size     = 2'b00;
        MemWrite = 1'b0;
        tick();
        check_eq("sbusy_req", mem_req, 1);
        check_eq("sbusy_addr", mem_addr, 32'h0000_5000);
        check_eq("sbusy_be", mem_be, 4'b1100);
        check_eq("sbusy_done0", done, 0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("sbusy_done1", done, 1);
        tick();
        start = 1'b0;
        check_eq("sbusy_done2", done, 0);
        check_eq("sbusy_idle", busy, 0);
        tick();
        check_eq("sbusy_done3", done, 0);
        check_eq("sbusy_req3", mem_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_align.md
# load_store_align

Sub-word data-memory access unit for the single-cycle/multi-cycle CPU datapath. It is the narrowing and lane-steering counterpart of the immediate extender. On stores it packs a 32-bit register value into byte, halfword or word lanes with byte enables. On loads it extracts the addressed lane from the memory word and sign- or zero-extends it to 32 bits. It sits between the ALU/register file and data memory, and talks to memory through a req/ack handshake so that it tolerates multi-cycle memories.

## Interface
Parameters:
- none (fixed 32-bit data, 32-bit byte address, little-endian lanes)

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- Reset  in  1  asynchronous, active-high reset
- start  in  1  request a new access; sampled only in IDLE
- MemWrite  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- ExtSel  in  1  load extension: 1 sign-extend, 0 zero-extend; ignored for word and store
- addr  in  32  byte address
- wdata  in  32  store data; the low byte or halfword is used for sub-word stores
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- misalign  out  1  valid while done is high; 1 = access rejected
- rdata  out  32  extended load result, held until the next completed load
- mem_req  out  1  memory request
- mem_we  out  1  memory write strobe, qualified by mem_req
- mem_addr  out  32  word address, {addr[31:2], 2'b00}
- mem_be  out  4  byte enables; bit i controls byte lane i (bits 8i+7:8i)
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completion; sampled only in REQ
- mem_rdata  in  32  read word, valid in the cycle mem_ack is high

## Operation
States are IDLE, REQ and DONE. Reset forces IDLE.

- **IDLE.** When start = 1, all inputs are captured into registers.
  - If the access is illegal, the next state is DONE with misalign = 1 and no memory request is made. An access is illegal when size = 11, or size = 01 with addr[0] = 1, or size = 10 with addr[1:0] != 0.
  - Otherwise the next state is REQ.
- **REQ.** mem_req = 1 and mem_we = the captured MemWrite. mem_addr, mem_be and mem_wdata come from the captured values and stay stable for the whole of REQ. On the edge where mem_ack = 1, the next state is DONE; for loads, rdata is updated on that same edge. If mem_ack = 0, the unit stays in REQ indefinitely.
- **DONE.** done = 1 for exactly one cycle, then the next state is IDLE. A start input during DONE is ignored.

Byte enables:
- byte: mem_be = 4'b0001 << addr[1:0]
- halfword: mem_be = addr[1] ? 4'b1100 : 4'b0011
- word: mem_be = 4'b1111
- for loads, mem_be is driven with the same pattern

Store data:
- byte: mem_wdata = {4{wdata[7:0]}}
- halfword: mem_wdata = {2{wdata[15:0]}}
- word: mem_wdata = wdata

Load data:
- byte: the lane is mem_rdata[8*addr[1:0] +: 8]; bits 31:8 are ExtSel ? lane[7] replicated : 0
- halfword: the lane is mem_rdata[16*addr[1] +: 16]; bits 31:16 are extended the same way
- word: rdata = mem_rdata

Other rules:
- A store or a misaligned access leaves rdata unchanged.
- A mem_ack in IDLE or DONE is ignored.
- A start input while busy = 1 is ignored, with no queuing.

## Timing
- Reset values: state IDLE; busy, done, misalign, mem_req and mem_we are 0; rdata, mem_addr, mem_be and mem_wdata are 0.
- Reset asserted mid-access returns the unit to IDLE immediately (asynchronously) and drops mem_req in the same cycle. The interrupted access does not produce a done pulse.
- Aligned access: start is sampled at edge 0 and mem_req is high from edge 0. If mem_ack arrives k cycles later (k ≥ 1), it is sampled at edge k and done is high from edge k to edge k+1. With a zero-wait memory (ack high in the first REQ cycle), the minimum start-to-done latency is 2 cycles.
- Misaligned access: start at edge 0 gives done = 1 and misalign = 1 from edge 0 to edge 1. mem_req is never asserted.
- A back-to-back start is accepted at the earliest one cycle after done, that is in IDLE.
- misalign is cleared when the next access is accepted.

## Test plan
- **sb, zero-wait memory:** addr = 0x1003, wdata = 0x000000A5 -> mem_be = 1000, mem_wdata = 0xA5A5A5A5, mem_addr = 0x1000, done pulses 2 cycles after start.
- **lb signed vs unsigned:** mem_rdata = 0x80FF7F01, addr = 0x2001, ExtSel = 1 -> rdata = 0x0000007F. The same at addr = 0x2002 gives 0xFFFFFFFF with ExtSel = 1 and 0x000000FF with ExtSel = 0.
- **lh upper half, memory waits 3 cycles:** ExtSel = 1, addr = 0x2002, mem_rdata = 0x8001xxxx -> rdata = 0xFFFF8001. mem_req and all memory outputs stay stable for all 3 cycles, and done comes one cycle after ack.
- **Misaligned accesses:** sh at 0x3001, lw at 0x3002, or size = 11 -> mem_req never asserted, done = 1 and misalign = 1 one cycle after start, rdata unchanged.
- **Reset and stray ack:** assert Reset while in REQ -> mem_req drops asynchronously, no done pulse; after release, busy = 0 and a new sw completes normally. Separately, a mem_ack pulse while in IDLE -> no state change.
- **Start while busy:** pulse start during REQ and during DONE -> both ignored, exactly one done pulse.
